wb_uart_msg_master: RTL

- Parametrised Wishbone master that drives the wbuart slave to transmit a programmable N-byte message on a start trigger.
- Successor to the fixed-string push-button controller. Adds:
  - message length, baud divisor and inter-byte gap as parameters;
  - the message taken from a port and latched at start;
  - repeat mode, ack timeout with an error flag, and busy/done status.
- Sits between board-level trigger logic and wbuart; it is the only Wishbone master on that bus.

---
 rtl/wb_uart_msg_master_if.sv | 16 +
 rtl/wb_uart_msg_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_uart_msg_master_if.sv
// Wishbone bus bundle between the message master and the wbuart slave.
interface wb_uart_msg_master_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [1:0]  o_wb_addr;
   logic [31:0] o_wb_data;
   logic        i_wb_ack;
   logic [31:0] i_wb_data;

   modport master (output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
                   input  i_wb_ack, i_wb_data);
   modport slave  (input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
                   output i_wb_ack, i_wb_data);
endinterface

// File: rtl/wb_uart_msg_master.sv
// Wishbone master that programs wbuart once, then sends an N-byte message per start trigger,
// with inter-byte gap, optional continuous repeat and an ack timeout.
module wb_uart_msg_master #(
   parameter int unsigned MSG_LEN     = 10,
   parameter int unsigned BAUD_DIV    = 434,
   parameter int unsigned SETUP_WAIT  = 50000000,
   parameter int unsigned GAP_CYCLES  = 15000,
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter int unsigned REPEAT      = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [8*MSG_LEN-1:0]   i_msg,
   wb_uart_msg_master_if.master   wb,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);
   localparam int unsigned MAX_A = (SETUP_WAIT > GAP_CYCLES) ? SETUP_WAIT : GAP_CYCLES;
   localparam int unsigned MAX_W = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam int IDX_W = $clog2(MSG_LEN) + 1;
   localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SETUP_WAIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SWAIT, LOAD, WRITE, GAP, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [8*MSG_LEN-1:0] msg_q, msg_d;
   logic                 err_q, err_d, sdone_q, sdone_d;
   logic                 start_q, start_qq;
   logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [3:0]           sel_q, sel_d;
   logic [1:0]           addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic                 start_rise;
   logic [7:0]           cur_byte;
   logic                 unused_rdata;

   assign start_rise   = start_q & ~start_qq;
   assign cur_byte     = msg_q[8*int'(idx_q) +: 8];
   assign unused_rdata = ^wb.i_wb_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      msg_d   = msg_q;
      err_d   = err_q;
      sdone_d = sdone_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: if (start_rise) begin
            msg_d = i_msg;
            err_d = 1'b0;
            idx_d = '0;
            cnt_d = '0;
            if (sdone_q) state_d = LOAD;
            else begin
               state_d = SETUP;
               {cyc_d, stb_d, we_d} = 3'b111;
               sel_d  = 4'hF;
               addr_d = 2'b00;
               data_d = 32'(BAUD_DIV);
            end
         end
         SETUP, WRITE: begin
            // ack is checked before the timeout so a last-cycle ack still completes
            if (wb.i_wb_ack) begin
               {cyc_d, stb_d, we_d} = 3'b000;
               sel_d  = 4'h0;
               addr_d = 2'b00;
               data_d = '0;
               cnt_d  = '0;
               if (state_q == SETUP) begin
                  sdone_d = 1'b1;
                  state_d = SWAIT;
               end else if (idx_q == IDX_LAST) state_d = DONE;
               else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = GAP;
               end
            end else if (cnt_q == TO_LAST) begin
               {cyc_d, stb_d, we_d} = 3'b000;
               sel_d   = 4'h0;
               addr_d  = 2'b00;
               data_d  = '0;
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         SWAIT: if (cnt_q == SW_LAST) begin
            cnt_d   = '0;
            state_d = LOAD;
         end else cnt_d = cnt_q + CNT_W'(1);
         LOAD: begin
            {cyc_d, stb_d, we_d} = 3'b111;
            sel_d   = 4'hF;
            addr_d  = 2'b11;
            data_d  = {24'd0, cur_byte};
            cnt_d   = '0;
            state_d = WRITE;
         end
         GAP: if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = LOAD;
         end else cnt_d = cnt_q + CNT_W'(1);
         DONE: begin
            idx_d = '0;
            if (REPEAT != 0 && i_start) begin
               msg_d   = i_msg;
               cnt_d   = '0;
               state_d = GAP;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         msg_q    <= '0;
         err_q    <= 1'b0;
         sdone_q  <= 1'b0;
         start_q  <= 1'b0;
         start_qq <= 1'b0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= 4'h0;
         addr_q   <= 2'b00;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         msg_q    <= msg_d;
         err_q    <= err_d;
         sdone_q  <= sdone_d;
         start_q  <= i_start;
         start_qq <= start_q;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign wb.o_wb_cyc  = cyc_q;
   assign wb.o_wb_stb  = stb_q;
   assign wb.o_wb_we   = we_q;
   assign wb.o_wb_sel  = sel_q;
   assign wb.o_wb_addr = addr_q;
   assign wb.o_wb_data = data_q;
   assign o_busy       = (state_q != IDLE);
   assign o_done       = (state_q == DONE);
   assign o_err        = err_q;
endmodule
